// File: rtl/i2c_target_if.sv
// ============================================================================
// Module   : i2c_target_if
// Purpose  : Register-file side of the I2C target (pointer, write/read strobes).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface i2c_target_if;
  logic [7:0] reg_addr;
  logic [7:0] wr_data;
  logic       wr_stb;
  logic [7:0] rd_data;
  logic       rd_stb;
  logic       busy;

  // master: the I2C target block; slave: the register file it serves
  modport master (output reg_addr, wr_data, wr_stb, rd_stb, busy, input rd_data);
  modport slave  (input reg_addr, wr_data, wr_stb, rd_stb, busy, output rd_data);
endinterface

`default_nettype wire

// File: rtl/i2c_target.sv
// ============================================================================
// Module   : i2c_target
// Purpose  : I2C target with 8-bit register pointer, auto-increment and reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h76
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  inout  wire  sda,
  i2c_target_if.master regs
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_t;

  state_t     r_state;
  logic [1:0] r_scl_s;
  logic [1:0] r_sda_s;
  logic       r_scl_d;
  logic       r_sda_d;
  logic [1:0] r_settle;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_tx;
  logic       r_rw;
  logic       r_sda_oe;
  logic [7:0] r_reg_addr;
  logic [7:0] r_wr_data;
  logic       r_wr_stb;
  logic       r_rd_stb;
  logic       r_busy;

  logic w_valid;
  logic w_scl;
  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  // Edges are masked until the synchronizer and delay stages hold real bus
  // values, so a bus sitting low after reset cannot fake a START.
  assign w_valid    = (r_settle == 2'd3);
  assign w_scl      = r_scl_s[1];
  assign w_sda      = r_sda_s[1];
  assign w_scl_rise = w_valid &  w_scl & ~r_scl_d;
  assign w_scl_fall = w_valid & ~w_scl &  r_scl_d;
  assign w_start    = w_valid & w_scl & r_scl_d &  r_sda_d & ~w_sda;
  assign w_stop     = w_valid & w_scl & r_scl_d & ~r_sda_d &  w_sda;

  assign sda           = r_sda_oe ? 1'b0 : 1'bz;
  assign regs.reg_addr = r_reg_addr;
  assign regs.wr_data  = r_wr_data;
  assign regs.wr_stb   = r_wr_stb;
  assign regs.rd_stb   = r_rd_stb;
  assign regs.busy     = r_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scl_s    <= 2'b11;
      r_sda_s    <= 2'b11;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
      r_settle   <= 2'd0;
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 4'd0;
      r_shift    <= 8'd0;
      r_tx       <= 8'd0;
      r_rw       <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_reg_addr <= 8'd0;
      r_wr_data  <= 8'd0;
      r_wr_stb   <= 1'b0;
      r_rd_stb   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_scl_s  <= {r_scl_s[0], scl};
      r_sda_s  <= {r_sda_s[0], sda};
      r_scl_d  <= r_scl_s[1];
      r_sda_d  <= r_sda_s[1];
      if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
      r_wr_stb <= 1'b0;
      r_rd_stb <= 1'b0;
      // Pointer advances the clk after a write strobe, so the strobe sees the old address.
      if (r_wr_stb) r_reg_addr <= r_reg_addr + 8'd1;

      if (w_stop) begin
        r_state   <= ST_IDLE;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
        r_bit_cnt <= 4'd0;
      end else if (w_start) begin
        r_state   <= ST_ADDR;
        r_sda_oe  <= 1'b0;
        r_bit_cnt <= 4'd0;
      end else begin
        case (r_state)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (w_scl_rise && (r_bit_cnt != 4'd8)) begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
              r_bit_cnt <= 4'd0;
              if (r_state == ST_ADDR) begin
                if (r_shift[7:1] == DEV_ADDR) begin
                  r_rw     <= r_shift[0];
                  r_busy   <= 1'b1;
                  r_sda_oe <= 1'b1;
                  r_state  <= ST_ADDR_ACK;
                end else begin
                  r_state  <= ST_WAIT_STOP;
                end
              end else if (r_state == ST_PTR) begin
                r_reg_addr <= r_shift;
                r_sda_oe   <= 1'b1;
                r_state    <= ST_PTR_ACK;
              end else begin
                r_wr_data  <= r_shift;
                r_wr_stb   <= 1'b1;
                r_sda_oe   <= 1'b1;
                r_state    <= ST_WDATA_ACK;
              end
            end
          end

          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= 4'd0;
              if (r_state == ST_ADDR_ACK && r_rw) begin
                r_rd_stb <= 1'b1;
                r_tx     <= regs.rd_data;
                r_sda_oe <= ~regs.rd_data[7];
                r_state  <= ST_RDATA;
              end else if (r_state == ST_ADDR_ACK) begin
                r_state  <= ST_PTR;
              end else begin
                r_state  <= ST_WDATA;
              end
            end
          end

          ST_RDATA: begin
            if (w_scl_rise && (r_bit_cnt != 4'd8)) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= 4'd0;
                r_state   <= ST_RDATA_ACK;
              end else begin
                r_sda_oe  <= ~r_tx[3'd7 - r_bit_cnt[2:0]];
              end
            end
          end

          // Count 9 marks "master acked": the pointer moves at the rise so the
          // register file has the next byte ready by the reload at the fall.
          ST_RDATA_ACK: begin
            if (w_scl_rise && (r_bit_cnt == 4'd0)) begin
              if (!w_sda) begin
                r_reg_addr <= r_reg_addr + 8'd1;
                r_bit_cnt  <= 4'd9;
              end else begin
                r_state    <= ST_WAIT_STOP;
              end
            end else if (w_scl_fall && (r_bit_cnt == 4'd9)) begin
              r_rd_stb  <= 1'b1;
              r_tx      <= regs.rd_data;
              r_sda_oe  <= ~regs.rd_data[7];
              r_bit_cnt <= 4'd0;
              r_state   <= ST_RDATA;
            end
          end

          ST_IDLE, ST_WAIT_STOP: begin
            r_sda_oe <= 1'b0;
          end

          default: begin
            r_state  <= ST_IDLE;
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_target.sv
// ============================================================================
// Module   : tb_i2c_target
// Purpose  : Directed bus-master bench for i2c_target with a register-file model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_target;

  localparam int Q = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tb_scl = 1'b1;
  logic tb_sda_low = 1'b0;
  wire  sda;

  logic [7:0] mem [256];
  logic [7:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  logic [7:0] rd_addr_q [$];
  int both_cnt = 0;
  int dut_low_cnt = 0;
  int busy_cnt = 0;
  int n_tests = 0;
  int n_fail = 0;

  i2c_target_if regs_if ();

  assign sda = tb_sda_low ? 1'b0 : 1'bz;
  pullup (sda);
  assign regs_if.rd_data = mem[regs_if.reg_addr];

  i2c_target #(.DEV_ADDR(7'h76)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .scl   (tb_scl),
    .sda   (sda),
    .regs  (regs_if.master)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (regs_if.wr_stb) begin
      wr_addr_q.push_back(regs_if.reg_addr);
      wr_data_q.push_back(regs_if.wr_data);
    end
    if (regs_if.rd_stb) rd_addr_q.push_back(regs_if.reg_addr);
    if (regs_if.wr_stb && regs_if.rd_stb) both_cnt++;
    if (sda === 1'b0 && !tb_sda_low) dut_low_cnt++;
    if (regs_if.busy) busy_cnt++;
  end

  task automatic hold();
    repeat (Q) @(negedge clk);
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    dut_low_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic i2c_start();
    tb_sda_low = 1'b0; hold();
    tb_scl = 1'b1;     hold();
    tb_sda_low = 1'b1; hold();
    tb_scl = 1'b0;     hold();
  endtask

  task automatic i2c_stop();
    tb_sda_low = 1'b1; hold();
    tb_scl = 1'b1;     hold();
    tb_sda_low = 1'b0; hold();
  endtask

  // Drives one bit (1 = released) and returns sda sampled mid-high.
  task automatic send_bit(input logic b, output logic s);
    tb_sda_low = ~b; hold();
    tb_scl = 1'b1;   hold();
    s = sda;         hold();
    tb_scl = 1'b0;   hold();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    acked = (s == 1'b0);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      b[i] = s;
    end
    send_bit(~master_ack, s);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++; if (regs_if.reg_addr !== 8'h00) begin n_fail++; $display("FAIL reset_reg_addr: got %h exp 00", regs_if.reg_addr); end
    n_tests++; if (regs_if.wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %h exp 00", regs_if.wr_data); end
    n_tests++; if (regs_if.wr_stb !== 1'b0) begin n_fail++; $display("FAIL reset_wr_stb: got %b exp 0", regs_if.wr_stb); end
    n_tests++; if (regs_if.rd_stb !== 1'b0) begin n_fail++; $display("FAIL reset_rd_stb: got %b exp 0", regs_if.rd_stb); end
    n_tests++; if (regs_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", regs_if.busy); end
    n_tests++; if (sda !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b exp 1 (released)", sda); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    logic busy_mid;
    clear_logs();
    i2c_start();
    write_byte(8'hEC, a0);
    write_byte(8'h10, a1);
    write_byte(8'hAB, a2);
    busy_mid = regs_if.busy;
    i2c_stop();
    hold();
    n_tests++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL write_acks: got %b exp 111", {a0, a1, a2}); end
    n_tests++; if (busy_mid !== 1'b1) begin n_fail++; $display("FAIL write_busy_mid: got %b exp 1", busy_mid); end
    n_tests++; if (wr_addr_q.size() != 1) begin n_fail++; $display("FAIL write_stb_count: got %0d exp 1", wr_addr_q.size()); end
    n_tests++; if (wr_addr_q[0] !== 8'h10) begin n_fail++; $display("FAIL write_stb_addr: got %h exp 10", wr_addr_q[0]); end
    n_tests++; if (wr_data_q[0] !== 8'hAB) begin n_fail++; $display("FAIL write_stb_data: got %h exp ab", wr_data_q[0]); end
    n_tests++; if (regs_if.reg_addr !== 8'h11) begin n_fail++; $display("FAIL write_ptr_after: got %h exp 11", regs_if.reg_addr); end
    n_tests++; if (regs_if.busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_after: got %b exp 0", regs_if.busy); end
  endtask

  task automatic test_nomatch();
    logic a0;
    clear_logs();
    i2c_start();
    write_byte(8'hA0, a0);
    i2c_stop();
    hold();
    n_tests++; if (a0 !== 1'b0) begin n_fail++; $display("FAIL nomatch_ack: got %b exp 0", a0); end
    n_tests++; if (dut_low_cnt != 0) begin n_fail++; $display("FAIL nomatch_sda_driven: got %0d low clks exp 0", dut_low_cnt); end
    n_tests++; if (wr_addr_q.size() + rd_addr_q.size() != 0) begin n_fail++; $display("FAIL nomatch_strobes: got %0d exp 0", wr_addr_q.size() + rd_addr_q.size()); end
    n_tests++; if (busy_cnt != 0) begin n_fail++; $display("FAIL nomatch_busy: got %0d busy clks exp 0", busy_cnt); end
  endtask

  task automatic test_read();
    logic a0, a1, a2;
    logic [7:0] b0, b1;
    clear_logs();
    mem[8'h05] = 8'h5A;
    mem[8'h06] = 8'hC3;
    i2c_start();
    write_byte(8'hEC, a0);
    write_byte(8'h05, a1);
    i2c_start();
    write_byte(8'hED, a2);
    read_byte(1'b1, b0);
    read_byte(1'b0, b1);
    i2c_stop();
    hold();
    n_tests++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL read_acks: got %b exp 111", {a0, a1, a2}); end
    n_tests++; if (b0 !== 8'h5A) begin n_fail++; $display("FAIL read_byte0: got %h exp 5a", b0); end
    n_tests++; if (b1 !== 8'hC3) begin n_fail++; $display("FAIL read_byte1: got %h exp c3", b1); end
    n_tests++; if (rd_addr_q.size() != 2) begin n_fail++; $display("FAIL read_stb_count: got %0d exp 2", rd_addr_q.size()); end
    n_tests++; if (rd_addr_q[0] !== 8'h05) begin n_fail++; $display("FAIL read_stb_addr0: got %h exp 05", rd_addr_q[0]); end
    n_tests++; if (rd_addr_q[1] !== 8'h06) begin n_fail++; $display("FAIL read_stb_addr1: got %h exp 06", rd_addr_q[1]); end
    n_tests++; if (wr_addr_q.size() != 0) begin n_fail++; $display("FAIL read_no_wr_stb: got %0d exp 0", wr_addr_q.size()); end
    n_tests++; if (regs_if.reg_addr !== 8'h06) begin n_fail++; $display("FAIL read_ptr_after: got %h exp 06", regs_if.reg_addr); end
  endtask

  task automatic test_wrap();
    logic a0, a1, a2, a3;
    clear_logs();
    i2c_start();
    write_byte(8'hEC, a0);
    write_byte(8'hFF, a1);
    write_byte(8'h11, a2);
    write_byte(8'h22, a3);
    i2c_stop();
    hold();
    n_tests++; if ({a0, a1, a2, a3} !== 4'b1111) begin n_fail++; $display("FAIL wrap_acks: got %b exp 1111", {a0, a1, a2, a3}); end
    n_tests++; if (wr_addr_q.size() != 2) begin n_fail++; $display("FAIL wrap_stb_count: got %0d exp 2", wr_addr_q.size()); end
    n_tests++; if (wr_addr_q[0] !== 8'hFF || wr_data_q[0] !== 8'h11) begin n_fail++; $display("FAIL wrap_first: got %h/%h exp ff/11", wr_addr_q[0], wr_data_q[0]); end
    n_tests++; if (wr_addr_q[1] !== 8'h00 || wr_data_q[1] !== 8'h22) begin n_fail++; $display("FAIL wrap_second: got %h/%h exp 00/22", wr_addr_q[1], wr_data_q[1]); end
    n_tests++; if (regs_if.reg_addr !== 8'h01) begin n_fail++; $display("FAIL wrap_ptr_after: got %h exp 01", regs_if.reg_addr); end
  endtask

  task automatic test_reset_mid();
    logic a0, a1, a2, s;
    clear_logs();
    i2c_start();
    write_byte(8'hEC, a0);
    write_byte(8'h40, a1);
    for (int i = 0; i < 3; i++) send_bit(1'b1, s);
    tb_sda_low = 1'b0; hold();
    tb_scl = 1'b1;
    repeat (Q / 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (sda !== 1'b1) begin n_fail++; $display("FAIL rstmid_sda: got %b exp 1 (released)", sda); end
    n_tests++; if (regs_if.busy !== 1'b0 || regs_if.reg_addr !== 8'h00) begin n_fail++; $display("FAIL rstmid_state: got busy %b ptr %h exp 0/00", regs_if.busy, regs_if.reg_addr); end
    hold();
    tb_scl = 1'b0; hold();
    for (int i = 0; i < 4; i++) send_bit(1'b1, s);
    send_bit(1'b1, s);
    n_tests++; if (s !== 1'b1) begin n_fail++; $display("FAIL rstmid_no_ack: got %b exp 1", s); end
    i2c_stop();
    hold();
    n_tests++; if (wr_addr_q.size() != 0) begin n_fail++; $display("FAIL rstmid_no_wr_stb: got %0d exp 0", wr_addr_q.size()); end
    i2c_start();
    write_byte(8'hEC, a0);
    write_byte(8'h20, a1);
    write_byte(8'h77, a2);
    i2c_stop();
    hold();
    n_tests++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL rstmid_next_acks: got %b exp 111", {a0, a1, a2}); end
    n_tests++; if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 8'h20 || wr_data_q[0] !== 8'h77) begin n_fail++; $display("FAIL rstmid_next_write: got n=%0d %h/%h exp 1 20/77", wr_addr_q.size(), wr_addr_q[0], wr_data_q[0]); end
  endtask

  task automatic test_stop_midbyte();
    logic a0, a1, s;
    logic [4:0] bits;
    clear_logs();
    bits = 5'b01010;
    i2c_start();
    write_byte(8'hEC, a0);
    write_byte(8'h30, a1);
    for (int i = 4; i >= 0; i--) send_bit(bits[i], s);
    i2c_stop();
    hold();
    n_tests++; if ({a0, a1} !== 2'b11) begin n_fail++; $display("FAIL stopmid_acks: got %b exp 11", {a0, a1}); end
    n_tests++; if (wr_addr_q.size() != 0) begin n_fail++; $display("FAIL stopmid_no_wr_stb: got %0d exp 0", wr_addr_q.size()); end
    n_tests++; if (regs_if.busy !== 1'b0) begin n_fail++; $display("FAIL stopmid_busy: got %b exp 0", regs_if.busy); end
    n_tests++; if (regs_if.reg_addr !== 8'h30) begin n_fail++; $display("FAIL stopmid_ptr: got %h exp 30", regs_if.reg_addr); end
  endtask

  task automatic test_back_to_back();
    logic a0, a1, a2;
    clear_logs();
    i2c_start();
    write_byte(8'hEC, a0);
    write_byte(8'h50, a1);
    write_byte(8'h01, a2);
    i2c_stop();
    i2c_start();
    write_byte(8'hEC, a0);
    write_byte(8'h60, a1);
    write_byte(8'h02, a2);
    i2c_stop();
    hold();
    n_tests++; if (wr_addr_q.size() != 2) begin n_fail++; $display("FAIL b2b_stb_count: got %0d exp 2", wr_addr_q.size()); end
    n_tests++; if (wr_addr_q[0] !== 8'h50 || wr_data_q[0] !== 8'h01) begin n_fail++; $display("FAIL b2b_first: got %h/%h exp 50/01", wr_addr_q[0], wr_data_q[0]); end
    n_tests++; if (wr_addr_q[1] !== 8'h60 || wr_data_q[1] !== 8'h02) begin n_fail++; $display("FAIL b2b_second: got %h/%h exp 60/02", wr_addr_q[1], wr_data_q[1]); end
    n_tests++; if (both_cnt != 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d clks exp 0", both_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_write();
    test_nomatch();
    test_read();
    test_wrap();
    test_reset_mid();
    test_stop_midbyte();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
